// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, writes it into
// instruction memory one 32-bit little-endian word per strobe, checks an XOR
// checksum, and releases the datapath reset only after a clean load.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // Running checksum step: 8-bit XOR accumulation.
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // True for the states that consume bytes.
  function automatic logic is_active(input state_t s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CHK);
  endfunction

  state_t            state_r, state_s;
  logic              byte_ready_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              core_reset_r;
  logic              done_r;
  logic              error_r;

  logic [7:0]        n_lo_r;
  logic [15:0]       n_r;
  logic [15:0]       word_cnt_r;
  logic [1:0]        byte_cnt_r;
  logic [7:0]        chk_r;
  logic [23:0]       word_buf_r;

  logic              xfer_s;
  logic              dxfer_s;
  logic              wr_s;
  logic              start_clr_s;
  logic              last_byte_s;
  logic [15:0]       nword_s;

  // Next-state decode, write request and session-start detection.
  always_comb begin
    state_s     = state_r;
    wr_s        = 1'b0;
    start_clr_s = 1'b0;
    xfer_s      = byte_valid & byte_ready_r;
    dxfer_s     = xfer_s & ~abort;
    nword_s     = {byte_data, n_lo_r};
    last_byte_s = (byte_cnt_r == 2'd3) && (word_cnt_r == (n_r - 16'd1));
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_s     = S_HDR0;
          start_clr_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_HDR0: begin
        if (abort) begin
          state_s = S_ERR;
        end else if (xfer_s) begin
          state_s = S_HDR1;
        end else begin
          state_s = S_HDR0;
        end
      end
      S_HDR1: begin
        if (abort) begin
          state_s = S_ERR;
        end else if (xfer_s) begin
          if (nword_s == 16'd0) begin
            state_s = S_CHK;
          end else if ({16'd0, nword_s} > (32'd1 << ADDR_W)) begin
            state_s = S_ERR;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_HDR1;
        end
      end
      S_DATA: begin
        if (abort) begin
          state_s = S_ERR;
        end else if (xfer_s) begin
          wr_s = (byte_cnt_r == 2'd3);
          if (last_byte_s) begin
            state_s = S_CHK;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_CHK: begin
        if (abort) begin
          state_s = S_ERR;
        end else if (xfer_s) begin
          if (byte_data == chk_r) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end else begin
          state_s = S_CHK;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      byte_ready_r <= 1'b0;
      core_reset_r <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_ready_r <= is_active(state_s);
      core_reset_r <= (state_s != S_DONE);
      done_r       <= (state_s == S_DONE);
      error_r      <= (state_s == S_ERR);
    end
  end

  // Header capture, word assembly, checksum and the memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      n_lo_r       <= 8'd0;
      n_r          <= 16'd0;
      word_cnt_r   <= 16'd0;
      byte_cnt_r   <= 2'd0;
      chk_r        <= 8'd0;
      word_buf_r   <= 24'd0;
    end else begin
      imem_we_r <= wr_s;
      if (start_clr_s) begin
        word_cnt_r <= 16'd0;
        byte_cnt_r <= 2'd0;
        chk_r      <= 8'd0;
      end else if (dxfer_s && (state_r == S_HDR0)) begin
        n_lo_r <= byte_data;
      end else if (dxfer_s && (state_r == S_HDR1)) begin
        n_r <= nword_s;
      end else if (dxfer_s && (state_r == S_DATA)) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        chk_r      <= chk_step(chk_r, byte_data);
        case (byte_cnt_r)
          2'd0:    word_buf_r[7:0]   <= byte_data;
          2'd1:    word_buf_r[15:8]  <= byte_data;
          2'd2:    word_buf_r[23:16] <= byte_data;
          default: begin
            imem_addr_r  <= ADDR_W'(word_cnt_r);
            imem_wdata_r <= {byte_data, word_buf_r};
            word_cnt_r   <= word_cnt_r + 16'd1;
          end
        endcase
      end else begin
        n_r <= n_r;
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign core_reset = core_reset_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scenario tasks drive byte streams; expected
// memory writes go into a scoreboard queue and a negedge monitor pops them.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  int   tests = 0;
  int   fails = 0;
  wr_t  expq[$];
  logic [7:0] txq[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every observed write must match the queue head.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if ({imem_addr, imem_wdata} !== {e.addr, e.data}) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    cycles(n);
    start = 1'b0;
  endtask

  // One byte per cycle; optional abort on the same cycle.
  task automatic send_byte(input logic [7:0] b, input logic ab);
    byte_valid = 1'b1;
    byte_data  = b;
    abort      = ab;
    @(negedge clk);
    tests++;
    if (byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL byte_ready: got %b, expected 1 for byte %02h", byte_ready, b);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic send_txq();
    while (txq.size() > 0) send_byte(txq.pop_front(), 1'b0);
  endtask

  task automatic check_status(input string nm, input logic d, input logic e, input logic cr);
    @(negedge clk);
    tests++;
    if ({done, error, core_reset} !== {d, e, cr}) begin
      fails++;
      $display("FAIL %s: got done/error/core_reset=%b%b%b, expected %b%b%b", nm, done, error, core_reset, d, e, cr);
    end
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL %s_writes: got %0d writes outstanding, expected 0", nm, expq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string nm);
    tests++;
    if ({byte_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error} !==
        {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s: got rdy=%b we=%b addr=%0d data=%08h cr=%b done=%b err=%b, expected 0 0 0 00000000 1 0 0",
               nm, byte_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error);
    end
  endtask

  // Standard two-word stream; payload XOR is 20^01^08 = 0x29.
  task automatic load_two_words(input logic [7:0] chk);
    expq.push_back('{addr: 10'd0, data: 32'h0001_0020});
    expq.push_back('{addr: 10'd1, data: 32'h0000_0008});
    txq = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h01, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, chk};
    send_txq();
  endtask

  task automatic test_reset();
    cycles(2);
    @(negedge clk);
    check_reset_vals("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(2);
    @(negedge clk);
    check_reset_vals("idle_after_release");
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    pulse_start(2);  // start held into HDR0 must be ignored
    load_two_words(8'h29);
    check_status("load_ok", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    pulse_start(1);
    load_two_words(8'h28);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_zero_and_oversize();
    pulse_start(1);
    txq = '{8'h00, 8'h00, 8'h00};
    send_txq();
    check_status("zero_words", 1'b1, 1'b0, 1'b0);
    pulse_start(1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);  // N = 1025
    @(negedge clk);
    tests++;
    if ({error, byte_ready} !== 2'b10) begin
      fails++;
      $display("FAIL oversize: got error=%b byte_ready=%b, expected 1 0", error, byte_ready);
    end
    @(posedge clk); #1;
    pulse_start(1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);  // N = 1024 is the largest legal count
    @(negedge clk);
    tests++;
    if ({error, byte_ready} !== 2'b01) begin
      fails++;
      $display("FAIL max_size: got error=%b byte_ready=%b, expected 0 1", error, byte_ready);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    check_status("abort_idle_byte", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    pulse_start(1);
    txq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send_txq();
    send_byte(8'hDD, 1'b1);
    check_status("abort_4th", 1'b0, 1'b1, 1'b1);
    abort = 1'b1;  // abort in ERR has no effect
    cycles(1);
    abort = 1'b0;
    pulse_start(1);
    expq.push_back('{addr: 10'd0, data: 32'hDDCC_BBAA});
    txq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_txq();
    check_status("after_abort", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    pulse_start(1);
    tests++;
    if ({core_reset, done} !== 2'b10) begin
      fails++;
      $display("FAIL restart: got core_reset=%b done=%b, expected 1 0", core_reset, done);
    end
    expq.push_back('{addr: 10'd0, data: 32'h1234_5678});
    txq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_txq();
    check_status("restart_load", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    pulse_start(1);
    expq.push_back('{addr: 10'd0, data: 32'h4433_2211});
    txq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_txq();
    reset = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    cycles(3);
    reset = 1'b1;
    cycles(3);
    check_status("after_reset_mid", 1'b0, 1'b0, 1'b1);
    check_reset_vals("idle_no_restart");
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_checksum();
    test_zero_and_oversize();
    test_abort();
    test_restart();
    test_reset_mid();
    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
